// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths, constants and write-back request bundle for the register bank.
package regbank_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] dr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
  function automatic logic [REG_COUNT-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
    return {{(REG_COUNT-1){1'b0}}, 1'b1} << r;
  endfunction
endpackage

// File: rtl/regbank_wb_sched_if.sv
// regbank_wb_sched_if: issue, read-select, write-back request and bank write signals of the scheduler.
interface regbank_wb_sched_if;
  import regbank_pkg::*;
  logic iss_valid;
  logic [REG_ADDR_W-1:0] iss_dr;
  logic iss_ready;
  logic [REG_ADDR_W-1:0] sr1, sr2;
  logic hazard1, hazard2;
  logic rq0_valid, rq1_valid;
  logic [REG_ADDR_W-1:0] rq0_dr, rq1_dr;
  logic [REG_DATA_W-1:0] rq0_data, rq1_data;
  logic rq0_ready, rq1_ready;
  logic write;
  logic [REG_ADDR_W-1:0] dr;
  logic [REG_DATA_W-1:0] wrData;
  logic [REG_COUNT-1:0] pending;
  modport slave (
    input iss_valid, iss_dr, sr1, sr2, rq0_valid, rq0_dr, rq0_data, rq1_valid, rq1_dr, rq1_data,
    output iss_ready, hazard1, hazard2, rq0_ready, rq1_ready, write, dr, wrData, pending
  );
  modport master (
    output iss_valid, iss_dr, sr1, sr2, rq0_valid, rq0_dr, rq0_data, rq1_valid, rq1_dr, rq1_data,
    input iss_ready, hazard1, hazard2, rq0_ready, rq1_ready, write, dr, wrData, pending
  );
endinterface

// File: rtl/regbank_wb_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on contention the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic last;
  always_comb begin
    grant[0] = req[0] && (!req[1] || last);
    grant[1] = req[1] && (!req[0] || !last);
  end
  // reset value 1 gives rq0 first priority
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (|grant) last <= grant[1];
endmodule

// File: rtl/regbank_wb_sched.sv
// regbank_wb_sched: merges two write-back requesters onto the bank write port and tracks pending destinations.
module regbank_wb_sched
  import regbank_pkg::*;
(
  input logic clk,
  input logic rst,
  regbank_wb_sched_if.slave bus
);
  wb_req_t rq0, rq1;
  logic [1:0] grant;
  logic [REG_ADDR_W-1:0] gdr, dr;
  logic [REG_DATA_W-1:0] gdata, wr_data;
  logic [REG_COUNT-1:0] pending, set_vec, clr_vec;
  logic write;
  assign rq0 = {bus.rq0_valid, bus.rq0_dr, bus.rq0_data};
  assign rq1 = {bus.rq1_valid, bus.rq1_dr, bus.rq1_data};
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req({rq1.valid, rq0.valid}), .grant(grant));
  assign gdr = grant[1] ? rq1.dr : rq0.dr;
  assign gdata = grant[1] ? rq1.data : rq0.data;
  assign bus.rq0_ready = grant[0];
  assign bus.rq1_ready = grant[1];
  assign bus.iss_ready = !pending[bus.iss_dr];
  assign bus.hazard1 = pending[bus.sr1];
  assign bus.hazard2 = pending[bus.sr2];
  // set is ORed after the clear so a same-edge reissue keeps the bit
  assign set_vec = (bus.iss_valid && bus.iss_ready && bus.iss_dr != REG_ZERO) ? reg_bit(bus.iss_dr) : '0;
  assign clr_vec = write ? reg_bit(dr) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) pending <= '0;
    else pending <= (pending & ~clr_vec) | set_vec;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      write <= 1'b0;
      dr <= REG_ZERO;
      wr_data <= '0;
    end else if (|grant) begin
      write <= gdr != REG_ZERO;
      dr <= gdr;
      wr_data <= gdata;
    end else write <= 1'b0;
  assign bus.write = write;
  assign bus.dr = dr;
  assign bus.wrData = wr_data;
  assign bus.pending = pending;
endmodule

// File: tb/tb_regbank_wb_sched.sv
// tb_regbank_wb_sched: directed and random checks of the write-back scheduler against a reference model.
module tb_regbank_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  bit m_pend [32];
  int m_prio;
  bit m_write;
  logic [4:0] m_dr;
  logic [31:0] m_data;

  regbank_wb_sched_if bus();
  regbank_wb_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.rq0_valid = 1'b0;
    bus.rq1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_prio = 0;
    m_write = 1'b0;
    m_dr = '0;
    m_data = '0;
    #1;
    chk("rst_write", bus.write, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_dr", bus.dr, 0);
    chk("rst_wrdata", bus.wrData, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic tick();
    int g;
    bit iss_ok;
    #1;
    g = (bus.rq0_valid && bus.rq1_valid) ? m_prio : bus.rq0_valid ? 0 : bus.rq1_valid ? 1 : -1;
    iss_ok = !m_pend[bus.iss_dr];
    chk("rq0_ready", bus.rq0_ready, g == 0);
    chk("rq1_ready", bus.rq1_ready, g == 1);
    chk("iss_ready", bus.iss_ready, iss_ok);
    chk("hazard1", bus.hazard1, m_pend[bus.sr1]);
    chk("hazard2", bus.hazard2, m_pend[bus.sr2]);
    if (m_write) m_pend[m_dr] = 1'b0;
    if (bus.iss_valid && iss_ok && bus.iss_dr != 0) m_pend[bus.iss_dr] = 1'b1;
    if (g >= 0) begin
      m_dr = g ? bus.rq1_dr : bus.rq0_dr;
      m_data = g ? bus.rq1_data : bus.rq0_data;
      m_write = m_dr != 0;
      m_prio = 1 - g;
    end else m_write = 1'b0;
    @(posedge clk);
    #1;
    chk("write", bus.write, m_write);
    chk("dr", bus.dr, m_dr);
    chk("wrdata", bus.wrData, m_data);
    chk("pending", bus.pending, model_vec());
  endtask

  initial begin
    logic [4:0] exp_dr [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    idle();
    bus.iss_dr = '0;
    bus.sr1 = '0;
    bus.sr2 = '0;
    bus.rq0_dr = '0;
    bus.rq1_dr = '0;
    bus.rq0_data = '0;
    bus.rq1_data = '0;
    do_reset();
    // single requester
    bus.rq0_valid = 1'b1;
    bus.rq0_dr = 5'd5;
    bus.rq0_data = 32'hDEADBEEF;
    #1 chk("tp_rq0_ready", bus.rq0_ready, 1);
    tick();
    idle();
    chk("tp_write1", bus.write, 1);
    chk("tp_dr5", bus.dr, 5);
    chk("tp_data", bus.wrData, 32'hDEADBEEF);
    tick();
    chk("tp_write0", bus.write, 0);
    // contention alternates starting with rq0
    do_reset();
    bus.rq0_valid = 1'b1;
    bus.rq0_dr = 5'd1;
    bus.rq0_data = 32'h1111;
    bus.rq1_valid = 1'b1;
    bus.rq1_dr = 5'd2;
    bus.rq1_data = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tp_rr_dr", bus.dr, exp_dr[i]);
    end
    idle();
    tick();
    // scoreboard set / WAW stall / commit
    bus.iss_valid = 1'b1;
    bus.iss_dr = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    chk("tp_pend7", bus.pending, 32'h80);
    bus.sr1 = 5'd7;
    #1 chk("tp_haz7", bus.hazard1, 1);
    bus.iss_valid = 1'b1;
    #1 chk("tp_waw", bus.iss_ready, 0);
    tick();
    bus.iss_valid = 1'b0;
    bus.rq1_valid = 1'b1;
    bus.rq1_dr = 5'd7;
    bus.rq1_data = 32'h7777;
    tick();
    bus.rq1_valid = 1'b0;
    #1 chk("tp_haz_commit", bus.hazard1, 1);
    tick();
    chk("tp_haz_after", bus.hazard1, 0);
    chk("tp_pend_clear", bus.pending, 0);
    // register zero
    bus.iss_valid = 1'b1;
    bus.iss_dr = 5'd0;
    #1 chk("tp_r0_ready", bus.iss_ready, 1);
    tick();
    bus.iss_valid = 1'b0;
    chk("tp_r0_pend", bus.pending, 0);
    bus.rq0_valid = 1'b1;
    bus.rq0_dr = 5'd0;
    bus.rq0_data = 32'h1;
    #1 chk("tp_r0_grant", bus.rq0_ready, 1);
    tick();
    bus.rq0_valid = 1'b0;
    chk("tp_r0_nowrite", bus.write, 0);
    bus.sr2 = 5'd0;
    #1 chk("tp_r0_haz", bus.hazard2, 0);
    // commit and reissue of r3 on the same edge
    bus.rq0_valid = 1'b1;
    bus.rq0_dr = 5'd3;
    bus.rq0_data = 32'h3333;
    tick();
    bus.rq0_valid = 1'b0;
    bus.iss_valid = 1'b1;
    bus.iss_dr = 5'd3;
    tick();
    bus.iss_valid = 1'b0;
    chk("tp_setwins", bus.pending[3], 1);
    // asynchronous reset mid-operation
    do_reset();
    for (int r = 8; r < 12; r++) begin
      bus.iss_valid = 1'b1;
      bus.iss_dr = 5'(r);
      tick();
    end
    bus.iss_valid = 1'b0;
    bus.rq1_valid = 1'b1;
    bus.rq1_dr = 5'd12;
    bus.rq1_data = 32'hC0C0;
    tick();
    idle();
    chk("tp_pre_write", bus.write, 1);
    chk("tp_pre_pend", bus.pending, 32'h0000_0F00);
    bus.rq0_valid = 1'b1;
    bus.rq0_dr = 5'd1;
    bus.rq1_valid = 1'b1;
    bus.rq1_dr = 5'd2;
    do_reset();
    #1 chk("tp_post_rst_grant", bus.rq0_ready, 1);
    tick();
    chk("tp_post_rst_dr", bus.dr, 1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.iss_valid = 1'($urandom);
      bus.iss_dr = 5'($urandom_range(0, 9));
      bus.sr1 = 5'($urandom_range(0, 9));
      bus.sr2 = 5'($urandom_range(0, 9));
      bus.rq0_valid = 1'($urandom);
      bus.rq1_valid = 1'($urandom);
      bus.rq0_dr = 5'($urandom_range(0, 9));
      bus.rq1_dr = 5'($urandom_range(0, 9));
      bus.rq0_data = $urandom;
      bus.rq1_data = $urandom;
      if (i == 200) do_reset();
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regbank_wb_sched.md
# regbank_wb_sched

Write-back scheduler and hazard scoreboard for the 32x32 register bank. Merges two write-back requesters (main ALU path and a multi-cycle unit, e.g. mul/div or load) onto the bank's single write port through a round-robin arbiter and one registered output stage. Tracks every issued-but-uncommitted destination register. Flags read hazards on the bank's two read selects so the issue stage can stall.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register select width (32 registers; register 0 hardwired to zero)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  issuing instruction will later write iss_dr
- iss_dr  in  ADDR_W  destination of issuing instruction
- iss_ready  out  1  issue accepted (combinational)
- sr1, sr2  in  ADDR_W  read selects currently presented to the bank
- hazard1, hazard2  out  1  sr1/sr2 has a pending, uncommitted write (combinational)
- rq0_valid, rq1_valid  in  1  write-back request
- rq0_dr, rq1_dr  in  ADDR_W  write-back destination
- rq0_data, rq1_data  in  DATA_W  write-back value
- rq0_ready, rq1_ready  out  1  request granted this cycle (combinational)
- write  out  1  bank write enable (registered)
- dr  out  ADDR_W  bank write select (registered)
- wrData  out  DATA_W  bank write data (registered)
- pending  out  32  scoreboard vector, bit i = register i awaiting write

## Operation
- Scoreboard: 32-bit `pending`.
  - Bit 0 is constant 0.
  - Issue handshake: `iss_valid && iss_ready` with `iss_dr != 0` sets `pending[iss_dr]` at the edge.
  - `iss_ready = !pending[iss_dr]`. This is a WAW stall. Issues to r0 are always ready and set nothing.
- Hazards: `hazardN = pending[srN]`, so r0 never flags.
- Arbitration is round-robin over rq0/rq1 and uses a `last` register.
  - Both valid: grant the requester not equal to `last`.
  - One valid: grant it.
  - `rqN_ready = grant[N]`. At most one ready at a time.
  - `last` updates to the granted index on the edge of a grant.
- Output stage: on a grant edge, `write <= (gdr != 0)`, `dr <= gdr`, `wrData <= gdata`. With no grant, `write <= 0`; `dr` and `wrData` hold.
  - A grant with `gdr == 0` completes the handshake and produces no bank write.
- Commit: when `write == 1`, `pending[dr]` clears at the same edge the bank captures the data.
- Simultaneous events on one edge:
  - Commit and issue to the same register: the set wins, so the bit stays 1.
  - Commit of register X and issue of register Y: both apply.
- Requests for a register whose pending bit is 0 are still written. The scoreboard is advisory and never blocks write-back.
- Reset, asynchronous and applies at any point including mid-operation:
  - `pending = 0`, `write = 0`, `dr = 0`, `wrData = 0`, `last = 1` (rq0 has first priority after reset).
  - In-flight requests are dropped.

## Timing
- Request granted in cycle N → `write` high in cycle N+1 → bank updated at the end of N+1. A read in cycle N+2 returns the new value.
- Pending bit: set at the end of the issue cycle, cleared at the end of the commit cycle (N+1).
- `hazardN` is low from cycle N+2 onward.
- Throughput is one write per cycle, sustained.
- With both requesters continuously valid, grants strictly alternate.
- Combinational paths:
  - `iss_dr` → `iss_ready`.
  - `srN` → `hazardN`.
  - `rqN_valid` → `rqM_ready`.
  - No path runs from any output back to the same block's inputs.

## Structure
- Shared package `regbank_pkg`:
  - `REG_ADDR_W = 5`, `REG_DATA_W = 32`, `REG_COUNT = 32`, `REG_ZERO = 5'd0`.
  - A typedef for the write-back request bundle (valid, dr, data).
- One sub-module, `rr_arb2`: 2-way round-robin arbiter with `last` state, combinational grant, update on accept.
- The scoreboard and output register stay in the top module.

## Test plan
- Reset, then rq0 only: `rq0_valid=1`, `rq0_dr=5`, `rq0_data=32'hDEADBEEF` → `rq0_ready=1` in cycle 0; cycle 1 shows `write=1`, `dr=5`, `wrData=32'hDEADBEEF`; cycle 2 shows `write=0`.
- Contention: both valid for 4 cycles, rq0→r1, rq1→r2 → grant order after reset is rq0, rq1, rq0, rq1; `dr` sequence 1, 2, 1, 2.
- Scoreboard:
  - Issue r7 → `pending=32'h80`; `sr1=7` gives `hazard1=1`.
  - A second issue to r7 sees `iss_ready=0`.
  - rq1 writes r7 → hazard1 stays 1 through the commit cycle, 0 the cycle after; `pending=0`.
- r0 handling: issue r0 → `pending` unchanged and `iss_ready=1`. rq0 with `dr=0`, `data=1` → `rq0_ready=1` and `write` stays 0. `sr2=0` → `hazard2=0`.
- Same-edge set/clear: r3 committing while a new issue to r3 happens → `pending[3]` remains 1.
- Reset mid-operation: assert `rst` asynchronously while `write=1` and `pending=32'h0000_0F00` → `write=0` and `pending=0` immediately. After release, the first contention grant goes to rq0.
